// File: rtl/stream_source.sv
// Loadable buffer of signed TIS values streamed to a core port on a write/read handshake.
// Optional STREAM_SOURCE_CLAMP_EN saturates each streamed value to the TIS range of -999..999.
module stream_source #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 39,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [7:0]       len,
  input  logic             start,
  output logic             write,
  output logic [WIDTH-1:0] out,
  input  logic             read,
  output logic             busy,
  output logic             done,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [7:0]              len_q;
  logic [AW-1:0]           idx;
  logic [7:0]              len_eff;
  logic                    idle_or_done;
  logic                    last;

  function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH-1:0] v);
`ifdef STREAM_SOURCE_CLAMP_EN
    if (v > WIDTH'(999))
      return WIDTH'(999);
    else if (v < WIDTH'(-999))
      return WIDTH'(-999);
    else
      return v;
`else
    return v;
`endif
  endfunction

  assign idle_or_done = (state != SEND);
  assign len_eff      = (int'(len) > DEPTH) ? 8'(DEPTH) : len;
  assign last         = (8'(idx) == len_q - 8'd1);

  // Buffer has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (load_we && idle_or_done && (int'(load_addr) < DEPTH))
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      write <= 1'b0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      idx   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q <= len_eff;
            idx   <= '0;
            count <= '0;
            if (len_eff != 8'd0) begin
              state <= SEND;
              write <= 1'b1;
              busy  <= 1'b1;
              done  <= 1'b0;
              out   <= sat(mem[0]);
            end else begin
              state <= DONE;
              write <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          // Next value is fetched on the same edge as the transfer, so no bubble.
          if (write && read) begin
            count <= count + 8'd1;
            if (last) begin
              state <= DONE;
              write <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + AW'(1);
              out <= sat(mem[idx + AW'(1)]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_source.md
Name: stream_source

Overview:
- Input-stream node feeding the UP port of a top-row core, or the DOWN port of a bottom-row core, in the compiled TIS grid.
- Holds a loadable buffer of 11-bit signed values and presents them one at a time on the core-port write/read handshake.
- Also reports progress (count, done), so benches and the board top can compare against expected output counts.

Parameters:
- WIDTH, 11, data width; two's-complement TIS value.
- DEPTH, 39, buffer entries; max stream length; must be ≤255.
- AW, $clog2(DEPTH), buffer address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low; 0 resets all state immediately.
- load_we  input  1  buffer write strobe; honoured only in IDLE/DONE.
- load_addr  input  AW  buffer write address; addresses ≥DEPTH are ignored.
- load_data  input  WIDTH  buffer write data.
- len  input  8  stream length, sampled on start.
- start  input  1  begin streaming; honoured only in IDLE/DONE.
- write  output  1  value valid toward the core (the core's wready input).
- out  output  WIDTH  value presented to the core; registered.
- read  input  1  consumer acknowledge; one-cycle pulse when the core takes out.
- busy  output  1  high in SEND.
- done  output  1  high in DONE.
- count  output  8  values accepted by the consumer since the last start.

Behaviour:
- Reset (rst=0, async): state=IDLE, write=0, out=0, busy=0, done=0, count=0, idx=0, stored length=0. Buffer contents are not reset and are preserved across reset.
- States: IDLE, SEND, DONE.
- Buffer writes: on a clock edge with load_we=1 in IDLE or DONE, mem[load_addr]<=load_data. Writes in SEND are ignored.
- Start:
  - start=1 in IDLE/DONE latches L=min(len,DEPTH), sets idx=0 and count=0.
  - If L>0: go to SEND. Next cycle write=1, out=mem[0].
  - If L=0: go directly to DONE; write stays 0.
  - start in SEND is ignored.
- SEND handshake:
  - A transfer occurs on an edge where write=1 and read=1. At that edge count<=count+1.
  - If idx==L-1: go to DONE; write=0 and out holds its last value from the next cycle.
  - Otherwise idx<=idx+1, and out<=mem[idx+1] on the same edge, so write stays high with no bubble.
  - read=1 while write=0 is ignored.
  - read held high for k cycles consumes k values, one per cycle.
- Latency: first value valid 1 cycle after the start edge. Throughput is 1 value/cycle when read is held high.
- DONE: done=1 and write=0 until the next start. count holds its final value.
- Simultaneous events:
  - start and load_we on the same edge in IDLE/DONE: the write happens, and the stream starts at mem[0] reading the old content of the written entry if its address is 0. Mem is written on the edge; out is loaded from the pre-edge mem.
  - read and rst=0 together: reset wins.
- Reset mid-SEND: streaming aborts, write drops immediately (async), count=0, state=IDLE.

Optional Feature:
- Macro: STREAM_SOURCE_CLAMP_EN.
- Defined: each value is saturated to TIS range on its way to out. Values >999 give 999; values <-999 give -999; others pass through. Buffer contents are unchanged.
- Undefined: out is the raw buffer value.

Test Plan:
- Load mem[0..2]={5,-3,999}, len=3, start, read held high from cycle 1 → out sequence 5,-3,999 on consecutive cycles; done=1 after third transfer; count=3; write=0.
- Same load, read pulsed every 4th cycle → write stays 1 between pulses with out stable; each value consumed exactly once; count increments only on pulses.
- len=0, start → done=1 the next cycle, write never asserts, count=0. len=50, start → L clamps to 39 and exactly 39 transfers occur.
- Mid-stream (count=2 of 5) drive rst=0 → write=0 and count=0 without a clock edge. Release reset, then start → stream restarts at mem[0]; buffer contents unchanged.
- load_we/start during SEND → ignored: buffer contents and stream order unaltered. read with write=0 → count unchanged.
- With STREAM_SOURCE_CLAMP_EN, mem[0]=11'h400 (−1024) and mem[1]=1000 → out=−999 then 999. Without the macro → out=−1024 then 1000.
